hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for a 5-stage pipeline: a shadow copy of the EX/MEM/WB
// destination info drives operand forwarding, load-use stalls and branch
// squash sequencing.
//
// state | meaning
// ------+-------------------------------------------------------------
// START | post-reset warm-up, 2 cycles, bubbles injected, IF/ID cleared
// RUN   | normal issue; load-use stall or taken-branch squash as needed
// FLUSH | one bubble cycle after a taken branch, BR_TAKEN ignored
module hazard_ctrl_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_uses_ra,
    input  logic       id_uses_rb,
    input  logic [4:0] id_rd,
    input  logic       id_rf_le,
    input  logic       id_l,
    input  logic       br_taken,
    output logic       s,
    output logic       pc_le,
    output logic       npc_le,
    output logic       if_id_le,
    output logic       if_id_clr,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    typedef enum logic [1:0] {START, RUN, FLUSH} state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } shadow_t;

    state_t  state_q, state_d;
    logic    start_cnt_q, start_cnt_d;
    shadow_t ex_q, mem_q, wb_q;
    logic    load_use;
    logic    le;

    // GR0 is hardwired, so writes to it never create a dependency.
    function automatic logic hit(input shadow_t e, input logic [4:0] src);
        return e.we && (e.rd == src) && (e.rd != 5'd0);
    endfunction

    // Youngest producer wins: EX, then MEM, then WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic uses);
        logic [1:0] sel;
        sel = 2'b00;
        if (uses) begin
            if (hit(ex_q, src))       sel = 2'b01;
            else if (hit(mem_q, src)) sel = 2'b10;
            else if (hit(wb_q, src))  sel = 2'b11;
        end
        return sel;
    endfunction

    // Forwarding selects and load-use detection, purely combinational.
    always_comb begin
        fwd_a    = fwd_sel(id_ra, id_uses_ra);
        fwd_b    = fwd_sel(id_rb, id_uses_rb);
        load_use = ex_q.ld && ((id_uses_ra && hit(ex_q, id_ra)) ||
                               (id_uses_rb && hit(ex_q, id_rb)));
    end

    // State register and warm-up down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= START;
            start_cnt_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
        end
    end

    // Next-state and control outputs; reset overrides everything while held.
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        s           = 1'b0;
        if_id_clr   = 1'b0;
        le          = 1'b1;
        case (state_q)
            START: begin
                s         = 1'b1;
                if_id_clr = 1'b1;
                if (start_cnt_q == 1'b0) state_d = RUN;
                else                     start_cnt_d = start_cnt_q - 1'b1;
            end
            RUN: begin
                // A taken branch squashes the stalled consumer anyway.
                if (br_taken) begin
                    s         = 1'b1;
                    if_id_clr = 1'b1;
                    state_d   = FLUSH;
                end else if (load_use) begin
                    s  = 1'b1;
                    le = 1'b0;
                end
            end
            FLUSH: begin
                s       = 1'b1;
                state_d = RUN;
            end
            default: state_d = START;
        endcase
        if (reset) begin
            s         = 1'b1;
            if_id_clr = 1'b1;
            le        = 1'b0;
        end
        pc_le    = le;
        npc_le   = le;
        if_id_le = le;
    end

    // Shadow pipeline; a bubble enters EX whenever the bubble mux is selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= '{rd: id_rd, we: id_rf_le & ~s, ld: id_l & ~s};
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios followed by random traffic,
// all outputs compared against an instruction-history reference model.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_ra, id_rb, id_rd;
    logic       id_uses_ra, id_uses_rb, id_rf_le, id_l, br_taken;
    logic       s, pc_le, npc_le, if_id_le, if_id_clr;
    logic [1:0] fwd_a, fwd_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .reset(reset),
        .id_ra(id_ra), .id_rb(id_rb),
        .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_rd(id_rd), .id_rf_le(id_rf_le), .id_l(id_l),
        .br_taken(br_taken),
        .s(s), .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le),
        .if_id_clr(if_id_clr), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    // Reference model: the last three instructions issued, youngest first.
    typedef struct {
        int rd;
        bit we;
        bit ld;
    } instr_t;

    instr_t     hist[3];
    bit         m_reset;
    int         m_start_left;
    bit         m_flush;
    bit         e_s, e_clr, e_le;
    logic [1:0] e_fa, e_fb;

    function automatic bit writes(int k, int src);
        return hist[k].we && (hist[k].rd == src) && (src != 0);
    endfunction

    function automatic logic [1:0] fwd_of(int src, bit uses);
        if (!uses) return 2'b00;
        for (int k = 0; k < 3; k++)
            if (writes(k, src)) return 2'(k + 1);
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        bit lu;
        lu   = hist[0].ld && ((id_uses_ra && writes(0, int'(id_ra))) ||
                              (id_uses_rb && writes(0, int'(id_rb))));
        e_fa = fwd_of(int'(id_ra), id_uses_ra);
        e_fb = fwd_of(int'(id_rb), id_uses_rb);
        if (m_reset) begin
            e_s = 1; e_clr = 1; e_le = 0; e_fa = 2'b00; e_fb = 2'b00;
        end else if (m_start_left > 0) begin
            e_s = 1; e_clr = 1; e_le = 1;
        end else if (m_flush) begin
            e_s = 1; e_clr = 0; e_le = 1;
        end else if (br_taken) begin
            e_s = 1; e_clr = 1; e_le = 1;
        end else if (lu) begin
            e_s = 1; e_clr = 0; e_le = 0;
        end else begin
            e_s = 0; e_clr = 0; e_le = 1;
        end
    endtask

    task automatic check_all();
        predict();
        chk("s",         {1'b0, s},         {1'b0, e_s});
        chk("if_id_clr", {1'b0, if_id_clr}, {1'b0, e_clr});
        chk("pc_le",     {1'b0, pc_le},     {1'b0, e_le});
        chk("npc_le",    {1'b0, npc_le},    {1'b0, e_le});
        chk("if_id_le",  {1'b0, if_id_le},  {1'b0, e_le});
        chk("fwd_a",     fwd_a,             e_fa);
        chk("fwd_b",     fwd_b,             e_fb);
    endtask

    task automatic drive(input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                         input logic ub, input logic [4:0] rd, input logic le,
                         input logic l, input logic br);
        id_ra = ra; id_uses_ra = ua; id_rb = rb; id_uses_rb = ub;
        id_rd = rd; id_rf_le = le; id_l = l; br_taken = br;
        #1;
        check_all();
    endtask

    task automatic nop();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock edge: retire the model by one instruction, then sit at negedge.
    task automatic advance();
        @(posedge clk);
        if (!m_reset) begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{rd: int'(id_rd), we: id_rf_le && !e_s, ld: id_l && !e_s};
            if (m_start_left > 0) m_start_left--;
            else if (m_flush)     m_flush = 0;
            else if (br_taken)    m_flush = 1;
        end
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, hold across an edge, release on a negedge.
    task automatic do_reset();
        reset   = 1'b1;
        m_reset = 1;
        for (int k = 0; k < 3; k++) hist[k] = '{rd: 0, we: 0, ld: 0};
        m_start_left = 2;
        m_flush      = 0;
        #1;
        check_all();
        chk("rst_s",     {1'b0, s},         2'b01);
        chk("rst_clr",   {1'b0, if_id_clr}, 2'b01);
        chk("rst_pc_le", {1'b0, pc_le},     2'b00);
        chk("rst_fwd_a", fwd_a,             2'b00);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset   = 1'b0;
        m_reset = 0;
    endtask

    task automatic start_cycles();
        nop(); chk("start1_s", {1'b0, s}, 2'b01); chk("start1_clr", {1'b0, if_id_clr}, 2'b01);
        advance();
        nop(); chk("start2_s", {1'b0, s}, 2'b01); chk("start2_le", {1'b0, pc_le}, 2'b01);
        advance();
        nop(); chk("run_s", {1'b0, s}, 2'b00); chk("run_clr", {1'b0, if_id_clr}, 2'b00);
        chk("run_le", {1'b0, if_id_le}, 2'b01);
        advance();
    endtask

    initial begin
        reset = 1'b1;
        id_ra = '0; id_rb = '0; id_rd = '0;
        id_uses_ra = 0; id_uses_rb = 0; id_rf_le = 0; id_l = 0; br_taken = 0;
        do_reset();
        start_cycles();

        // Forwarding distance for a register-register producer of r3.
        drive(5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0); advance();
        drive(5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0); chk("dist1_fwd_a", fwd_a, 2'b01); advance();
        drive(5'd3, 1, 5'd0, 0, 5'd5, 1, 0, 0); chk("dist2_fwd_a", fwd_a, 2'b10); advance();
        drive(5'd3, 1, 5'd0, 0, 5'd6, 1, 0, 0); chk("dist3_fwd_a", fwd_a, 2'b11); advance();
        drive(5'd3, 1, 5'd0, 0, 5'd8, 1, 0, 0); chk("dist4_fwd_a", fwd_a, 2'b00); advance();

        // Load-use on RB: one stall cycle, then forward from MEM.
        drive(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0); advance();
        drive(5'd0, 0, 5'd5, 1, 5'd6, 1, 0, 0);
        chk("lu_s", {1'b0, s}, 2'b01); chk("lu_pc_le", {1'b0, pc_le}, 2'b00);
        advance();
        drive(5'd0, 0, 5'd5, 1, 5'd6, 1, 0, 0);
        chk("lu_after_s", {1'b0, s}, 2'b00); chk("lu_after_fwd_b", fwd_b, 2'b10);
        advance();

        // Writes (and a load) to r0 never hazard.
        drive(5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0); advance();
        drive(5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0); advance();
        drive(5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0); advance();
        drive(5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0);
        chk("r0_fwd_a", fwd_a, 2'b00); chk("r0_s", {1'b0, s}, 2'b00); advance();

        // Same rd in EX and MEM: youngest wins.
        drive(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0); advance();
        drive(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0); advance();
        drive(5'd7, 1, 5'd0, 0, 5'd2, 1, 0, 0); chk("young_fwd_a", fwd_a, 2'b01); advance();

        // Branch concurrent with load-use, then FLUSH ignoring BR_TAKEN.
        drive(5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0); advance();
        drive(5'd9, 1, 5'd0, 0, 5'd2, 1, 0, 1);
        chk("brlu_s", {1'b0, s}, 2'b01); chk("brlu_clr", {1'b0, if_id_clr}, 2'b01);
        chk("brlu_le", {1'b0, pc_le}, 2'b01);
        advance();
        drive(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
        chk("flush_s", {1'b0, s}, 2'b01); chk("flush_clr", {1'b0, if_id_clr}, 2'b00);
        advance();
        nop(); chk("post_flush_s", {1'b0, s}, 2'b00); advance();

        // Reset during a stall.
        drive(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0); advance();
        drive(5'd0, 0, 5'd5, 1, 5'd6, 1, 0, 0); chk("pre_rst_stall", {1'b0, pc_le}, 2'b00);
        do_reset();
        start_cycles();

        // Reset during FLUSH.
        drive(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1); advance();
        nop(); chk("pre_rst_flush", {1'b0, s}, 2'b01);
        do_reset();
        start_cycles();

        // Random traffic on a small register set to provoke frequent hazards.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
                advance();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
